trap_ctrl: RTL

// - Sits directly downstream of csr. Consumes is_trap / is_mret from the EXE stage.
// - Flushes the pipeline and redirects fetch to mtvec (trap) or mepc (mret).
// - Produces the mepc/mcause/mtval write strobes that csr commits on a trap.
// - Holds the redirect until the fetch unit accepts it; stalls EXE while busy.

---
 rtl/trap_ctrl_pkg.sv | 14 +
 rtl/trap_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - state encodings, cause codes and mtvec mask for trap_ctrl
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        TRAP_ST_IDLE  = 2'd0,
        TRAP_ST_FLUSH = 2'd1,
        TRAP_ST_REDIR = 2'd2
    } trap_state_t;

    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] MTVEC_BASE_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret flush and fetch redirect sequencer with csr trap write strobes
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] ECALL_CAUSE  = CAUSE_ECALL_M,
    parameter logic [31:0] EBRK_CAUSE   = CAUSE_BREAKPOINT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        exe_valid,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_inst,
    input  logic        is_trap,
    input  logic        is_mret,
    input  logic        is_ebreak,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic        ifu_ready,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_exe,
    output logic        exe_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        trap_we,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause,
    output logic [31:0] trap_mtval
);

    localparam int unsigned   CW     = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(FLUSH_CYCLES - 1);

    trap_state_t   r_state;
    trap_state_t   w_next_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_target;
    logic          r_trap_we;
    logic [31:0]   r_mepc;
    logic [31:0]   r_mcause;
    logic [31:0]   r_mtval;

    logic w_trigger;
    logic w_accept;
    logic w_trap_kind;

    assign w_trigger   = exe_valid & (is_trap | is_mret);
    assign w_accept    = (r_state == TRAP_ST_IDLE) & w_trigger;
    // mret outranks a simultaneous trap, mirroring csr priority
    assign w_trap_kind = is_trap & ~is_mret;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= TRAP_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TRAP_ST_IDLE:  if (w_trigger)         w_next_state = TRAP_ST_FLUSH;
            TRAP_ST_FLUSH: if (r_count == C_LAST) w_next_state = TRAP_ST_REDIR;
            TRAP_ST_REDIR: if (ifu_ready)         w_next_state = TRAP_ST_IDLE;
            default:                              w_next_state = TRAP_ST_IDLE;
        endcase
    end

    always_comb begin
        flush_if       = 1'b0;
        flush_id       = 1'b0;
        flush_exe      = 1'b0;
        exe_stall      = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            TRAP_ST_FLUSH: begin
                flush_if  = 1'b1;
                flush_id  = 1'b1;
                flush_exe = 1'b1;
                exe_stall = 1'b1;
            end
            TRAP_ST_REDIR: begin
                // keep IF empty until fetch actually takes the new PC
                flush_if       = ~ifu_ready;
                exe_stall      = 1'b1;
                redirect_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count   <= '0;
            r_target  <= '0;
            r_trap_we <= 1'b0;
            r_mepc    <= '0;
            r_mcause  <= '0;
            r_mtval   <= '0;
        end else begin
            r_trap_we <= w_accept & w_trap_kind;
            if (w_accept) begin
                r_count  <= '0;
                r_target <= is_mret ? csr_mepc : (csr_mtvec & MTVEC_BASE_MASK);
                if (w_trap_kind) begin
                    r_mepc   <= exe_pc;
                    r_mcause <= is_ebreak ? EBRK_CAUSE : ECALL_CAUSE;
                    r_mtval  <= exe_inst;
                end
            end else if (r_state == TRAP_ST_FLUSH) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign redirect_pc = r_target;
    assign trap_we     = r_trap_we;
    assign trap_mepc   = r_mepc;
    assign trap_mcause = r_mcause;
    assign trap_mtval  = r_mtval;

endmodule
